spi_dopi_read_seq: RTL and testbench

Octal DTR (8D-8D-8D) read sequencer for the `spiflash_8x` interface. It sits between the bus-side read port and the DDR I/O/DQS-capture PHY. Each accepted read request becomes the full MX66UM-style transaction: command, address, dummy cycles, then data. The DQS-aligned input byte pairs are packed into 32-bit words for the bus side.

---
 rtl/spi_dopi_read_seq.sv | 207 ++++++++++++++++++++
 tb/tb_spi_dopi_read_seq.sv | 247 ++++++++++++++++++++++++
 2 files changed

// File: rtl/spi_dopi_read_seq.sv
// spi_dopi_read_seq: octal DTR (8D-8D-8D) flash read sequencer.
// Drives cmd/addr/dummy phases and packs DQS byte pairs into 32-bit words.
module spi_dopi_read_seq #(
  parameter int DUMMY_CYCLES = 20,
  parameter int CSH_CYCLES   = 3,
  parameter int TIMEOUT      = 64
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_addr,
  input  logic [7:0]  req_len,
  output logic        rd_valid,
  output logic [31:0] rd_data,
  output logic        rd_last,
  output logic        err,
  output logic        cs_n,
  output logic        sclk_en,
  output logic [15:0] dq_o,
  output logic        dq_oe,
  input  logic [15:0] dq_i,
  input  logic        dq_i_valid
);

  localparam int DW = $clog2(DUMMY_CYCLES + 1);
  localparam int CW = $clog2(CSH_CYCLES + 1);
  localparam int IW = $clog2(TIMEOUT + 1);

  typedef enum logic [2:0] {
    IDLE, CMD, ADDR_H, ADDR_L,
    DUMMY, DATA, DRAIN, CS_HOLD
  } state_e;

  state_e        state_q, state_d;
  logic [31:0]   addr_q, addr_d;
  logic [8:0]    words_q, words_d;
  logic [9:0]    beats_q, beats_d;
  logic [9:0]    tgt_q, tgt_d;
  logic [DW-1:0] dmy_q, dmy_d;
  logic [CW-1:0] csh_q, csh_d;
  logic [IW-1:0] idle_q, idle_d;
  logic          half_q, half_d;
  logic [15:0]   lo_q, lo_d;
  logic [31:0]   rd_data_q, rd_data_d;
  logic          rd_valid_q, rd_valid_d;
  logic          rd_last_q, rd_last_d;
  logic          err_q, err_d;

  logic [8:0] len_w;
  logic       in_rx;
  logic       cap;
  logic       last_done;
  logic       abort;
  logic       beats_done;

  assign len_w = (req_len == 8'd0) ? 9'd256 : {1'b0, req_len};
  assign in_rx = (state_q == DATA) || (state_q == DRAIN);
  assign cap = in_rx && dq_i_valid;
  assign last_done = cap && half_q && (words_q == 9'd1);
  assign abort = in_rx && !dq_i_valid && (idle_q == IW'(TIMEOUT - 1));
  assign beats_done = (state_q == DATA) && (beats_q + 10'd1 == tgt_q);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= IDLE;
      addr_q     <= '0;
      words_q    <= '0;
      beats_q    <= '0;
      tgt_q      <= '0;
      dmy_q      <= '0;
      csh_q      <= '0;
      idle_q     <= '0;
      half_q     <= 1'b0;
      lo_q       <= '0;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
      rd_last_q  <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      addr_q     <= addr_d;
      words_q    <= words_d;
      beats_q    <= beats_d;
      tgt_q      <= tgt_d;
      dmy_q      <= dmy_d;
      csh_q      <= csh_d;
      idle_q     <= idle_d;
      half_q     <= half_d;
      lo_q       <= lo_d;
      rd_data_q  <= rd_data_d;
      rd_valid_q <= rd_valid_d;
      rd_last_q  <= rd_last_d;
      err_q      <= err_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (req_valid) state_d = CMD;
      CMD:     state_d = ADDR_H;
      ADDR_H:  state_d = ADDR_L;
      ADDR_L:  state_d = DUMMY;
      DUMMY:   if (dmy_q == '0) state_d = DATA;
      DATA: begin
        if (last_done || abort) state_d = CS_HOLD;
        else if (beats_done)    state_d = DRAIN;
      end
      DRAIN:   if (last_done || abort) state_d = CS_HOLD;
      CS_HOLD: if (csh_q == '0) state_d = IDLE;
    endcase
  end

  always_comb begin
    addr_d     = addr_q;
    words_d    = words_q;
    beats_d    = beats_q;
    tgt_d      = tgt_q;
    dmy_d      = dmy_q;
    csh_d      = csh_q;
    idle_d     = idle_q;
    half_d     = half_q;
    lo_d       = lo_q;
    rd_data_d  = rd_data_q;
    rd_valid_d = 1'b0;
    rd_last_d  = 1'b0;
    err_d      = 1'b0;

    if (state_q == IDLE && req_valid) begin
      addr_d  = req_addr & ~32'h1;
      words_d = len_w;
      tgt_d   = {len_w, 1'b0};
    end
    if (state_q == ADDR_L) dmy_d = DW'(DUMMY_CYCLES - 1);
    if (state_q == DUMMY) begin
      if (dmy_q != '0) dmy_d = dmy_q - DW'(1);
      beats_d = '0;
      idle_d  = '0;
      half_d  = 1'b0;
    end
    if (state_q == DATA) beats_d = beats_q + 10'd1;
    if (in_rx) idle_d = dq_i_valid ? '0 : idle_q + IW'(1);

    // First pair forms the low half; wire order is rising byte first.
    if (cap) begin
      if (!half_q) begin
        lo_d   = {dq_i[7:0], dq_i[15:8]};
        half_d = 1'b1;
      end else begin
        rd_data_d  = {dq_i[7:0], dq_i[15:8], lo_q};
        half_d     = 1'b0;
        rd_valid_d = 1'b1;
        words_d    = words_q - 9'd1;
        rd_last_d  = (words_q == 9'd1);
      end
    end
    if (abort) begin
      err_d  = 1'b1;
      half_d = 1'b0;
    end

    if (state_d == CS_HOLD && state_q != CS_HOLD)
      csh_d = CW'(CSH_CYCLES - 1);
    else if (state_q == CS_HOLD && csh_q != '0)
      csh_d = csh_q - CW'(1);
  end

  always_comb begin
    req_ready = 1'b0;
    cs_n      = 1'b0;
    sclk_en   = 1'b0;
    dq_o      = '0;
    dq_oe     = 1'b0;
    unique case (state_q)
      IDLE: begin
        req_ready = 1'b1;
        cs_n      = 1'b1;
      end
      CMD: begin
        sclk_en = 1'b1;
        dq_oe   = 1'b1;
        dq_o    = 16'hEE11;
      end
      ADDR_H: begin
        sclk_en = 1'b1;
        dq_oe   = 1'b1;
        dq_o    = addr_q[31:16];
      end
      ADDR_L: begin
        sclk_en = 1'b1;
        dq_oe   = 1'b1;
        dq_o    = addr_q[15:0];
      end
      DUMMY:   sclk_en = 1'b1;
      DATA:    sclk_en = 1'b1;
      DRAIN:   sclk_en = 1'b0;
      CS_HOLD: cs_n = 1'b1;
    endcase
  end

  assign rd_valid = rd_valid_q;
  assign rd_data  = rd_data_q;
  assign rd_last  = rd_last_q;
  assign err      = err_q;

endmodule

// File: tb/tb_spi_dopi_read_seq.sv
// tb_spi_dopi_read_seq: directed bench with a word scoreboard.
// Expected words are queued when pairs are prepared, popped on rd_valid.
module tb_spi_dopi_read_seq;

  localparam int D   = 20;
  localparam int CSH = 3;
  localparam int TO  = 64;

  logic        clk;
  logic        rst_n;
  logic        req_valid;
  logic        req_ready;
  logic [31:0] req_addr;
  logic [7:0]  req_len;
  logic        rd_valid;
  logic [31:0] rd_data;
  logic        rd_last;
  logic        err;
  logic        cs_n;
  logic        sclk_en;
  logic [15:0] dq_o;
  logic        dq_oe;
  logic [15:0] dq_i;
  logic        dq_i_valid;

  int errors = 0;
  int checks = 0;
  int rd_cnt = 0;
  int err_cnt = 0;
  logic [32:0] sb[$];
  logic [15:0] pr[512];

  spi_dopi_read_seq #(
    .DUMMY_CYCLES(D),
    .CSH_CYCLES(CSH),
    .TIMEOUT(TO)
  ) dut (
    .clk(clk),
    .rst_n(rst_n),
    .req_valid(req_valid),
    .req_ready(req_ready),
    .req_addr(req_addr),
    .req_len(req_len),
    .rd_valid(rd_valid),
    .rd_data(rd_data),
    .rd_last(rd_last),
    .err(err),
    .cs_n(cs_n),
    .sclk_en(sclk_en),
    .dq_o(dq_o),
    .dq_oe(dq_oe),
    .dq_i(dq_i),
    .dq_i_valid(dq_i_valid)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] pack_word(logic [15:0] p0, logic [15:0] p1);
    return {p1[7:0], p1[15:8], p0[7:0], p0[15:8]};
  endfunction

  task automatic tick();
    logic [32:0] e;
    @(posedge clk);
    #1;
    if (err) err_cnt++;
    if (rd_valid) begin
      rd_cnt++;
      checks++;
      assert (sb.size() != 0) else begin
        errors++;
        $error("FAIL rd_unexpected observed=%0h expected=none", rd_data);
      end
      if (sb.size() != 0) begin
        e = sb.pop_front();
        chk("rd_word", {rd_last, rd_data}, e);
      end
    end
  endtask

  task automatic prep(int nw);
    for (int k = 0; k < nw; k++) begin
      pr[2*k]   = 16'($urandom);
      pr[2*k+1] = 16'($urandom);
      sb.push_back({(k == nw - 1), pack_word(pr[2*k], pr[2*k+1])});
    end
  endtask

  task automatic do_req(logic [31:0] a, logic [7:0] n);
    chk("req_ready_idle", req_ready, 1);
    req_valid = 1'b1;
    req_addr  = a;
    req_len   = n;
    tick();
    req_valid = 1'b0;
    req_addr  = $urandom;
    req_len   = 8'($urandom);
    chk("cmd", {cs_n, sclk_en, dq_oe, dq_o}, {3'b011, 16'hEE11});
    chk("req_ready_busy", req_ready, 0);
    tick();
    chk("addr_h", {cs_n, sclk_en, dq_oe, dq_o}, {3'b011, a[31:16]});
    tick();
    chk("addr_l", {cs_n, sclk_en, dq_oe, dq_o}, {3'b011, a[15:1], 1'b0});
    for (int i = 0; i < D; i++) begin
      tick();
      chk("dummy", {cs_n, sclk_en, dq_oe}, 3'b010);
    end
    tick();
  endtask

  task automatic feed(int nw, int lat);
    int sc = 0;
    for (int c = 0; c < 2*nw + lat; c++) begin
      sc += int'(sclk_en);
      if (c >= lat) begin
        dq_i_valid = 1'b1;
        dq_i = pr[c-lat];
      end else begin
        dq_i_valid = 1'b0;
      end
      tick();
    end
    dq_i_valid = 1'b0;
    chk("sclk_beats", sc, 2*nw);
    chk("cs_hold_entry", {cs_n, req_ready}, 2'b10);
  endtask

  task automatic wait_idle();
    int h = 0;
    while (!req_ready && h < 50) begin
      chk("cs_hold_csn", cs_n, 1);
      h++;
      tick();
    end
    chk("cs_hold_len", h, CSH);
    chk("idle_after_hold", {req_ready, cs_n, sclk_en, dq_oe}, 4'b1100);
  endtask

  initial begin
    int rd0;
    int e0;
    int n;
    req_valid  = 1'b0;
    req_addr   = '0;
    req_len    = '0;
    dq_i       = '0;
    dq_i_valid = 1'b0;
    rst_n      = 1'b0;
    tick();
    tick();
    chk("reset",
        {req_ready, cs_n, sclk_en, dq_oe, rd_valid, rd_last, err, dq_o, rd_data},
        {7'b1100000, 16'h0, 32'h0});
    rst_n = 1'b1;
    tick();

    pr[0] = 16'hA1B2;
    pr[1] = 16'hC3D4;
    sb.push_back({1'b1, 32'hD4C3B2A1});
    do_req(32'h0000_0100, 8'd1);
    feed(1, 0);
    wait_idle();
    chk("t1_words", rd_cnt, 1);

    prep(4);
    rd0 = rd_cnt;
    do_req(32'h8000_0040, 8'd4);
    feed(4, 3);
    wait_idle();
    chk("t2_words", rd_cnt - rd0, 4);
    chk("t2_sb_empty", sb.size(), 0);

    prep(1);
    do_req(32'h0012_3457, 8'd1);
    feed(1, 2);
    wait_idle();

    prep(256);
    rd0 = rd_cnt;
    do_req(32'h0000_1000, 8'd0);
    feed(256, 2);
    wait_idle();
    chk("t4_words", rd_cnt - rd0, 256);
    chk("t4_sb_empty", sb.size(), 0);

    e0  = err_cnt;
    rd0 = rd_cnt;
    do_req(32'h0000_2000, 8'd2);
    dq_i_valid = 1'b1;
    dq_i = 16'h5A5A;
    tick();
    dq_i_valid = 1'b0;
    n = 1;
    while (err_cnt == e0 && n < 200) begin
      tick();
      n++;
    end
    chk("timeout_cycles", n, TO + 1);
    chk("timeout_csn", cs_n, 1);
    wait_idle();
    chk("timeout_err_pulses", err_cnt - e0, 1);
    chk("timeout_no_rd", rd_cnt - rd0, 0);

    prep(2);
    do_req(32'h0000_3000, 8'd2);
    feed(2, 1);
    wait_idle();

    rd0 = rd_cnt;
    e0  = err_cnt;
    req_valid = 1'b1;
    req_addr  = 32'h0000_5000;
    req_len   = 8'd1;
    tick();
    req_valid = 1'b0;
    repeat (8) tick();
    chk("pre_rst_dummy", {cs_n, sclk_en}, 2'b01);
    rst_n = 1'b0;
    #1;
    chk("rst_async", {cs_n, sclk_en, dq_oe, req_ready}, 4'b1001);
    tick();
    tick();
    rst_n = 1'b1;
    tick();
    chk("rst_no_rd", rd_cnt - rd0, 0);
    chk("rst_no_err", err_cnt - e0, 0);

    prep(3);
    do_req(32'h4444_0002, 8'd3);
    feed(3, 1);
    wait_idle();
    chk("final_sb_empty", sb.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
